// File: rtl/uio_bus_scheduler_pkg.sv
// Shared types and constants for the uio bus scheduler.
package uio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN    = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic       DIR_OUT  = 1'b1;
    localparam logic       DIR_IN   = 1'b0;
    localparam logic [7:0] OE_ALL   = 8'hFF;
    localparam logic [7:0] OE_NONE  = 8'h00;

endpackage

// File: rtl/uio_bus_scheduler_if.sv
// Requester handshake plus uio pad signals of the scheduler.
interface uio_bus_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int LEN_W = 4
);
    logic                  ena;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*DW-1:0]    req_data;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic [DW-1:0]         rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic [DW-1:0]         uio_in;
    logic [DW-1:0]         uio_out;
    logic [DW-1:0]         uio_oe;

    // Scheduler side.
    modport slave (
        input  ena, req, req_dir, req_data, req_len, uio_in,
        output gnt, done, rd_data, rd_valid, busy, uio_out, uio_oe
    );

    // User logic / pad ring side.
    modport master (
        output ena, req, req_dir, req_data, req_len, uio_in,
        input  gnt, done, rd_data, rd_valid, busy, uio_out, uio_oe
    );
endinterface

// File: rtl/uio_bus_scheduler_rr_arbiter.sv
// Rotating-priority pick: first asserted request at or after the pointer.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan NREQ positions starting at the pointer, wrapping at NREQ.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int pos;
            pos = (int'(i_ptr) + k) % NREQ;
            if (!o_valid && i_req[pos]) begin
                o_valid    = 1'b1;
                o_idx      = IDX_W'(pos);
                o_gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_scheduler.sv
// Time-shares the uio pad bus between NREQ requesters, one burst at a time,
// with a turnaround cycle on either side of every transfer.
module uio_bus_scheduler
    import uio_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int LEN_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    uio_bus_scheduler_if.slave   bus
);

    localparam int IDX_W = $clog2(NREQ);

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic                r_dir;
    logic [DW-1:0]       r_data;
    logic [LEN_W-1:0]    r_cnt;
    logic [NREQ-1:0]     r_gnt;
    logic                r_done;
    logic                r_rd_valid;
    logic                r_busy;
    logic [DW-1:0]       r_rd_data;
    logic [DW-1:0]       r_uio_out;
    logic [DW-1:0]       r_uio_oe;

    logic [NREQ-1:0]     w_pick_gnt;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_valid;
    logic [DW-1:0]       w_data_sel;
    logic [LEN_W-1:0]    w_len_sel;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Select the winning requester's data and length slices.
    always_comb begin
        w_data_sel = '0;
        w_len_sel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(w_pick_idx) == k) begin
                w_data_sel = bus.req_data[k*DW +: DW];
                w_len_sel  = bus.req_len[k*LEN_W +: LEN_W];
            end
        end
    end

    // Transaction FSM; every output is a register so the pads never glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_dir      <= DIR_IN;
            r_data     <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_data  <= '0;
            r_uio_out  <= '0;
            r_uio_oe   <= OE_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ena && w_pick_valid) begin
                        r_idx   <= w_pick_idx;
                        r_dir   <= bus.req_dir[w_pick_idx];
                        r_data  <= w_data_sel;
                        r_cnt   <= w_len_sel;
                        r_gnt   <= w_pick_gnt;
                        r_busy  <= 1'b1;
                        r_state <= TURN;
                    end
                end
                TURN: begin
                    // Pads only start driving after a full cycle with oe low.
                    r_uio_oe  <= (r_dir == DIR_OUT) ? OE_ALL : OE_NONE;
                    r_uio_out <= (r_dir == DIR_OUT) ? r_data : '0;
                    r_state   <= XFER;
                end
                XFER: begin
                    if (r_cnt == '0) begin
                        if (r_dir == DIR_IN) begin
                            r_rd_data <= bus.uio_in;
                        end
                        r_rd_valid <= (r_dir == DIR_IN);
                        r_done     <= 1'b1;
                        r_gnt      <= '0;
                        r_uio_oe   <= OE_NONE;
                        r_uio_out  <= '0;
                        r_ptr      <= (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                        r_state    <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    r_done     <= 1'b0;
                    r_rd_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = r_busy;
    assign bus.uio_out  = r_uio_out;
    assign bus.uio_oe   = r_uio_oe;

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Directed and randomized checks of uio_bus_scheduler against a transaction-level model.
module tb_uio_bus_scheduler;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int LEN_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_ptr = 0;
    logic [7:0] m_rd  = 8'h00;

    uio_bus_scheduler_if #(.NREQ(NREQ), .DW(DW), .LEN_W(LEN_W)) bus ();

    uio_bus_scheduler #(.NREQ(NREQ), .DW(DW), .LEN_W(LEN_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round robin rule: first pending requester at or after the pointer.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_gnt"},  32'(bus.gnt),  32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_rdv"},  32'(bus.rd_valid), 32'd0);
        chk({tag, "_oe"},   32'(bus.uio_oe), 32'd0);
    endtask

    // One full transaction starting from IDLE; the next rising edge is arbitration.
    task automatic txn(input int want, input bit drop_ena, input bit fix_en, input logic [7:0] fix_val);
        int         w;
        logic       d;
        logic [7:0] dat;
        int         len;
        logic [7:0] last_in;
        w = (want >= 0) ? want : pick(bus.req, m_ptr);
        if (w < 0) w = 0;
        d       = bus.req_dir[w];
        dat     = bus.req_data[w*DW +: DW];
        len     = int'(bus.req_len[w*LEN_W +: LEN_W]);
        last_in = 8'h00;
        cyc();
        chk("turn_gnt",  32'(bus.gnt), 32'(1 << w));
        chk("turn_oe",   32'(bus.uio_oe), 32'h00);
        chk("turn_busy", 32'(bus.busy), 32'd1);
        chk("turn_done", 32'(bus.done), 32'd0);
        for (int c = 0; c <= len; c++) begin
            cyc();
            chk("xfer_oe",   32'(bus.uio_oe), d ? 32'hFF : 32'h00);
            if (d) chk("xfer_out", 32'(bus.uio_out), 32'(dat));
            chk("xfer_gnt",  32'(bus.gnt), 32'(1 << w));
            chk("xfer_done", 32'(bus.done), 32'd0);
            bus.uio_in   = (fix_en && c == len) ? fix_val : 8'($urandom);
            last_in      = bus.uio_in;
            bus.req_data = 32'($urandom);
            bus.req_len  = 16'($urandom);
            if (drop_ena && c == 0) bus.ena = 1'b0;
        end
        cyc();
        if (!d) m_rd = last_in;
        chk("rel_done", 32'(bus.done), 32'd1);
        chk("rel_rdv",  32'(bus.rd_valid), d ? 32'd0 : 32'd1);
        chk("rel_rd",   32'(bus.rd_data), 32'(m_rd));
        chk("rel_gnt",  32'(bus.gnt), 32'd0);
        chk("rel_oe",   32'(bus.uio_oe), 32'h00);
        chk("rel_out",  32'(bus.uio_out), 32'h00);
        chk("rel_busy", 32'(bus.busy), 32'd1);
        m_ptr   = (w + 1) % NREQ;
        bus.ena = 1'b1;
        cyc();
        chk_idle("post");
        chk("post_rd", 32'(bus.rd_data), 32'(m_rd));
    endtask

    initial begin
        rst          = 1'b1;
        bus.ena      = 1'b1;
        bus.req      = 4'hF;
        bus.req_dir  = 4'h0;
        bus.req_data = '0;
        bus.req_len  = '0;
        bus.uio_in   = 8'h00;

        // Reset held three cycles with every requester asking.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_idle("rst");
            chk("rst_out", 32'(bus.uio_out), 32'h00);
            chk("rst_rd",  32'(bus.rd_data), 32'h00);
        end
        rst     = 1'b0;
        bus.req = 4'h0;
        cyc();
        chk_idle("idle0");

        // Single write from requester 2, len 2.
        bus.req      = 4'b0100;
        bus.req_dir  = 4'b0100;
        bus.req_data = 32'h00A5_0000;
        bus.req_len  = 16'h0200;
        txn(2, 1'b0, 1'b0, 8'h00);
        bus.req = 4'h0;

        // Single read from requester 1, len 0, pad value 3C.
        bus.req      = 4'b0010;
        bus.req_dir  = 4'b0000;
        bus.req_len  = 16'h0000;
        txn(1, 1'b0, 1'b1, 8'h3C);
        chk("read_3c", 32'(m_rd), 32'h3C);
        bus.req = 4'h0;

        // Fresh pointer, then all four held: rotation 0,1,2,3,0.
        rst = 1'b1;
        cyc();
        rst   = 1'b0;
        m_ptr = 0;
        m_rd  = 8'h00;
        cyc();
        chk_idle("rst2");
        for (int i = 0; i < 5; i++) begin
            bus.req     = 4'hF;
            bus.req_len = 16'h0000;
            txn(i % NREQ, 1'b0, 1'b0, 8'h00);
        end
        bus.req = 4'h0;

        // ena low with a pending request: nothing granted.
        bus.ena = 1'b0;
        bus.req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_idle("ena0");
        end
        // ena restored, then dropped during XFER: transfer still completes.
        bus.ena      = 1'b1;
        bus.req_dir  = 4'b0010;
        bus.req_data = 32'h0000_7700;
        bus.req_len  = 16'h0030;
        txn(-1, 1'b1, 1'b0, 8'h00);
        bus.req = 4'h0;

        // Randomized traffic checked against the round robin model.
        for (int i = 0; i < 40; i++) begin
            bus.req      = 4'($urandom_range(1, 15));
            bus.req_dir  = 4'($urandom);
            bus.req_data = 32'($urandom);
            bus.req_len  = 16'($urandom);
            txn(-1, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        end
        bus.req = 4'h0;
        cyc();

        // Reset during XFER of a write: outputs drop, no done pulse.
        bus.req      = 4'b1000;
        bus.req_dir  = 4'b1000;
        bus.req_data = 32'h5A00_0000;
        bus.req_len  = 16'h5000;
        cyc();
        chk("r6_gnt", 32'(bus.gnt), 32'b1000);
        cyc();
        chk("r6_oe",  32'(bus.uio_oe), 32'hFF);
        chk("r6_out", 32'(bus.uio_out), 32'h5A);
        rst = 1'b1;
        cyc();
        chk_idle("r6_rst");
        chk("r6_rst_out", 32'(bus.uio_out), 32'h00);
        rst     = 1'b0;
        bus.req = 4'h0;
        m_ptr   = 0;
        m_rd    = 8'h00;
        cyc();
        chk_idle("r6_after");

        // Pointer back at 0 after reset.
        bus.req     = 4'hF;
        bus.req_dir = 4'h0;
        bus.req_len = 16'h0000;
        txn(0, 1'b0, 1'b0, 8'h00);
        bus.req = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
